// File: rtl/layer_arb_pkg.sv
// Shared types and defaults for the frame-synchronous layer arbiter.
package layer_arb_pkg;

  localparam int NUM_LAYERS_DEF = 4;
  localparam int IDX_W_DEF      = $clog2(NUM_LAYERS_DEF);
  localparam int RGB_W_DEF      = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] prio;
    logic                 en;
  } layer_cfg_t;

endpackage

// File: rtl/layer_prio_select.sv
// Combinational minimum-priority search; on equal priority the lower layer index wins.
module layer_prio_select #(
  parameter int NUM_LAYERS = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_LAYERS-1:0]            req,
  input  logic [NUM_LAYERS-1:0][IDX_W-1:0] prio,
  output logic [IDX_W-1:0]                 idx,
  output logic                             valid
);

  logic [IDX_W-1:0] best;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    best  = '0;
    // strict compare keeps the earliest (lowest index) entry on ties
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (req[i] && (!valid || (prio[i] < best))) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
        best  = prio[i];
      end
    end
  end

endmodule

// File: rtl/layer_arbiter.sv
// Per-pixel layer arbiter with double-buffered priority/enable tables swapped at start of frame.
// Optional collision flags are built only when COLLISION_DETECT_EN is defined.
module layer_arbiter
  import layer_arb_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int RGB_W      = RGB_W_DEF,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        cfg_wr,
  output logic                        cfg_ready,
  input  logic [IDX_W-1:0]            cfg_layer,
  input  logic [IDX_W-1:0]            cfg_prio,
  input  logic                        cfg_enable,
  input  logic [NUM_LAYERS-1:0]       layer_req,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [RGB_W-1:0]            bg_rgb,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [IDX_W-1:0]            winner_idx,
  output logic                        winner_valid,
  output logic [NUM_LAYERS-1:0]       collision_out
);

  arb_state_t state, state_nxt;
  logic       rdy;
  logic       commit;
  logic       cfg_accept;
  logic       cfg_in_range;

  logic [NUM_LAYERS-1:0][IDX_W-1:0] pend_prio, act_prio;
  logic [NUM_LAYERS-1:0]            pend_en,   act_en;

  logic [NUM_LAYERS-1:0]       req_p1;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_p1;
  logic [RGB_W-1:0]            bg_p1;
  logic                        vld_p1;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;

  logic [RGB_W-1:0] rgb_p2;
  logic [IDX_W-1:0] idx_p2;
  logic             win_p2;
  logic             vld_p2;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      rdy   <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy   <= 1'b1;
    end
  end

  // The snapshot is taken on the edge that enters COMMIT, so a write accepted
  // in that same IDLE cycle lands in pending after the copy.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = rdy;
        if (startOfFrame) begin
          commit    = 1'b1;
          state_nxt = COMMIT;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cfg_accept   = cfg_wr && cfg_ready;
  assign cfg_in_range = (int'(cfg_layer) < NUM_LAYERS);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        pend_prio[i] <= IDX_W'(i);
        act_prio[i]  <= IDX_W'(i);
      end
      pend_en <= '1;
      act_en  <= '1;
    end else begin
      if (commit) begin
        act_prio <= pend_prio;
        act_en   <= pend_en;
      end
      if (cfg_accept && cfg_in_range) begin
        pend_prio[cfg_layer] <= cfg_prio;
        pend_en[cfg_layer]   <= cfg_enable;
      end
    end
  end

  // ---- stage 1: capture enabled requests and colours ----
  always_ff @(posedge clk) begin
    req_p1 <= layer_req & act_en;
    rgb_p1 <= layer_rgb;
    bg_p1  <= bg_rgb;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= 1'b1;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 2: priority search on the active table, register result ----
  layer_prio_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_select (
    .req   (req_p1),
    .prio  (act_prio),
    .idx   (sel_idx),
    .valid (sel_vld)
  );

  always_ff @(posedge clk) begin
    win_p2 <= sel_vld;
    idx_p2 <= sel_vld ? sel_idx : '0;
    rgb_p2 <= sel_vld ? rgb_p1[int'(sel_idx)*RGB_W +: RGB_W] : bg_p1;
  end

  // Data registers are not reset; the valid chain blanks the outputs instead.
  assign RGBOut       = vld_p2 ? rgb_p2 : '0;
  assign winner_idx   = vld_p2 ? idx_p2 : '0;
  assign winner_valid = vld_p2 && win_p2;

`ifdef COLLISION_DETECT_EN
  logic [NUM_LAYERS-1:0] acc;
  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] coll;

  // More than one bit set means every enabled requester overlaps another.
  assign hit = (vld_p1 && ((req_p1 & (req_p1 - NUM_LAYERS'(1))) != '0)) ? req_p1 : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc  <= '0;
      coll <= '0;
    end else if (commit) begin
      coll <= acc | hit;
      acc  <= '0;
    end else begin
      acc <= acc | hit;
    end
  end

  assign collision_out = coll;
`else
  assign collision_out = '0;
`endif

endmodule
